// File: rtl/digit_scan_pkg.sv
// ============================================================================
// Module   : digit_scan_pkg
// Purpose  : Shared types, constants and segment table for the digit scanner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package digit_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [1:0] SEL_OFF   = 2'd3;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}, entry i is the glyph for digit i.
  localparam logic [0:9][6:0] DIGIT_SEG = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] bcd_pattern(input logic [3:0] nib);
    if (nib > 4'd9) begin
      return SEG_DASH;
    end
    return DIGIT_SEG[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module   : bcd_to_seg
// Purpose  : Nibble to active-low seven-segment pattern; non-BCD shows a dash.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
  import digit_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_pattern(nib_i);

endmodule

`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
// ============================================================================
// Module   : digit_scan_ctrl
// Purpose  : 3-digit multiplexed display scanner with frame-aligned loading.
//            Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int GUARD     = 4,
  parameter int DEC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          bcd_in,
  input  logic                 bcd_valid,
  output logic                 bcd_ready,
  output logic [DEC_WIDTH-1:0] digit_sel,
  output logic [6:0]           seg_out
);

  localparam int              CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

  state_e                 state_q, state_d;
  logic [1:0]             slot_q, slot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [11:0]            disp_q, disp_d;
  logic [DEC_WIDTH-1:0]   sel_q, sel_d;
  logic [6:0]             seg_q, seg_d;

  logic                   frame_end;
  logic                   xfer;
  logic [3:0]             nib;
  logic [6:0]             nib_seg;
  logic                   lz_blank;

  assign frame_end = (state_q == SCAN) && (slot_q == 2'd2) && (cnt_q == CNT_MAX);
  assign bcd_ready = (state_q == IDLE) || frame_end;
  assign xfer      = bcd_valid && bcd_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SCAN;
          slot_d  = 2'd0;
          cnt_d   = '0;
          disp_d  = bcd_in;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
          if (xfer) begin
            disp_d = bcd_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next position so they register on the
  // same edge as the counters and line up with the cycle they describe.
  always_comb begin
    case (slot_d)
      2'd0:    nib = disp_d[3:0];
      2'd1:    nib = disp_d[7:4];
      default: nib = disp_d[11:8];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    if ((slot_d == 2'd2) && (disp_d[11:8] == 4'd0)) begin
      lz_blank = 1'b1;
    end else if ((slot_d == 2'd1) && (disp_d[11:4] == 8'd0)) begin
      lz_blank = 1'b1;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    sel_d = DEC_WIDTH'(SEL_OFF);
    seg_d = SEG_BLANK;
    if ((state_d == SCAN) && (cnt_d >= GUARD_CNT)) begin
      sel_d = DEC_WIDTH'(slot_d);
      seg_d = lz_blank ? SEG_BLANK : nib_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
      disp_q  <= '0;
      sel_q   <= DEC_WIDTH'(SEL_OFF);
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign digit_sel = sel_q;
  assign seg_out   = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
// ============================================================================
// Module   : tb_digit_scan_ctrl
// Purpose  : Directed per-cycle vectors for digit_scan_ctrl (CLK_DIV=8, GUARD=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digit_scan_ctrl;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BLANK;
`else
  localparam logic [6:0] LZ = P0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;
  logic        bcd_ready;
  logic [1:0]  digit_sel;
  logic [6:0]  seg_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(
    .CLK_DIV   (8),
    .GUARD     (2),
    .DEC_WIDTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .digit_sel (digit_sel),
    .seg_out   (seg_out)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [11:0] bcd;
    logic [1:0]  sel;
    logic [6:0]  seg;
    logic        ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic [11:0] b,
                              input logic [1:0] s, input logic [6:0] g, input logic rdy);
    vec_t e;
    e.rst = r; e.valid = v; e.bcd = b; e.sel = s; e.seg = g; e.ready = rdy;
    vecs.push_back(e);
  endfunction

  // One 24-cycle frame: 2 blank guard cycles then 6 lit cycles per slot,
  // ready only on the last cycle, where end_valid/end_bcd are offered.
  function automatic void add_frame(input logic hold_v, input logic [11:0] hold_b,
                                    input logic end_v, input logic [11:0] end_b,
                                    input logic [6:0] p0, input logic [6:0] p1,
                                    input logic [6:0] p2);
    logic [6:0] pat [3];
    pat[0] = p0; pat[1] = p1; pat[2] = p2;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 8; c++) begin
        logic last;
        last = (s == 2) && (c == 7);
        add(1'b0, last ? end_v : hold_v, last ? end_b : hold_b,
            (c < 2) ? 2'd3 : 2'(s), (c < 2) ? BLANK : pat[s], last);
      end
    end
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] s, input logic [6:0] g,
                           input logic rdy);
    check({tag, " digit_sel"}, {5'd0, digit_sel}, {5'd0, s});
    check({tag, " seg_out"}, seg_out, g);
    check({tag, " bcd_ready"}, {6'd0, bcd_ready}, {6'd0, rdy});
  endtask

  initial begin
    // reset, then 20 idle cycles
    for (int i = 0; i < 20; i++) add(1'b0, 1'b0, 12'h000, 2'd3, BLANK, 1'b1);
    // load 123 in IDLE; the load cycle itself still shows idle outputs
    add(1'b0, 1'b1, 12'h123, 2'd3, BLANK, 1'b1);
    add_frame(1'b0, 12'h000, 1'b0, 12'h000, P3, P2, P1);
    // 456 held all frame: only the frame-end cycle accepts it
    add_frame(1'b1, 12'h456, 1'b1, 12'h456, P3, P2, P1);
    add_frame(1'b0, 12'h000, 1'b1, 12'hA0F, P6, P5, P4);
    add_frame(1'b0, 12'h000, 1'b1, 12'h007, DASH, P0, DASH);
    add_frame(1'b0, 12'h000, 1'b0, 12'h000, P7, LZ, LZ);
    // partial frame, reset with valid in the middle of slot 1
    for (int c = 0; c < 8; c++) add(1'b0, 1'b0, 12'h000, (c < 2) ? 2'd3 : 2'd0, (c < 2) ? BLANK : P7, 1'b0);
    for (int c = 0; c < 4; c++) add(1'b0, 1'b0, 12'h000, (c < 2) ? 2'd3 : 2'd1, (c < 2) ? BLANK : LZ, 1'b0);
    add(1'b1, 1'b1, 12'h999, 2'd1, LZ, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 12'h000, 2'd3, BLANK, 1'b1);
    add(1'b0, 1'b1, 12'h210, 2'd3, BLANK, 1'b1);
    add_frame(1'b0, 12'h000, 1'b0, 12'h000, P0, P1, P2);

    rst = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bcd_valid = vecs[i].valid;
      bcd_in = vecs[i].bcd;
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].seg, vecs[i].ready);
    end

    // Reset on a frame-end transfer: the transfer must not be taken.
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      rst = 1'b0; bcd_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    check_out("frame_end_before_rst", 2'd2, P2, 1'b1);
    rst = 1'b1; bcd_valid = 1'b1; bcd_in = 12'h345;
    @(negedge clk);
    rst = 1'b0; bcd_valid = 1'b0;
    #1;
    check_out("after_rst_on_xfer", 2'd3, BLANK, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check_out($sformatf("stay_idle%0d", k), 2'd3, BLANK, 1'b1);
    end

    // Fresh load after reset: T+1..T+2 blank, T+3 shows ones digit.
    @(negedge clk);
    bcd_valid = 1'b1; bcd_in = 12'h345;
    @(negedge clk);
    bcd_valid = 1'b0;
    #1;
    check_out("reload_t1", 2'd3, BLANK, 1'b0);
    @(negedge clk);
    #1;
    check_out("reload_t2", 2'd3, BLANK, 1'b0);
    @(negedge clk);
    #1;
    check_out("reload_t3", 2'd0, P5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
